// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states,
// write-back and next-PC select codes, and the ALU operation constants.
package rv32i_pkg;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_L     = 7'b0000011;

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXE, I_EXE, B_EXE, LU_EXE, AU_EXE, J_EXE, JL_EXE,
    S_EXE, S_MEM, L_EXE, L_MEM, L_WB
  } state_e;

  typedef enum logic [2:0] {
    RFWD_ALU    = 3'd0,
    RFWD_DMEM   = 3'd1,
    RFWD_IMM    = 3'd2,
    RFWD_PC_IMM = 3'd3,
    RFWD_PC_4   = 3'd4
  } rfwd_sel_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2
  } pc_sel_e;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  // Only the right shifts keep funct7[5] for I-type; elsewhere it is immediate data.
  localparam logic [2:0] F3_SR   = 3'b101;

endpackage

// File: rtl/rv32i_alu_decoder.sv
// Maps {opcode, funct3, funct7[5]} to the 4-bit ALU operation code.
module rv32i_alu_decoder
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (opcode)
      OP_R:    alu_control = {funct7_5, funct3};
      OP_I:    alu_control = (funct3 == F3_SR) ? {funct7_5, funct3} : {1'b0, funct3};
      OP_B:    alu_control = ALU_SUB;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv32i_mc_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH, DECODE, then a per-type execute/memory/
// write-back sequence. Outputs are decoded from the current state and instruction.
module rv32i_mc_control_unit
  import rv32i_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] instr_code,
  input  logic            btaken,
  output logic            pc_en,
  output logic            reg_we,
  output logic            alu_src_sel,
  output logic [3:0]      alu_control,
  output logic [2:0]      rfwd_src_sel,
  output logic [1:0]      pc_src_sel,
  output logic            dmem_we,
  output logic            illegal_instr
);

  state_e     state;
  state_e     next_state;
  rfwd_sel_e  rfwd_sel;
  pc_sel_e    pc_sel;
  logic [6:0] opcode;
  logic [3:0] alu_dec;
  logic       unused_instr_bits;

  assign opcode            = instr_code[6:0];
  assign unused_instr_bits = ^{instr_code[XLEN-1:31], instr_code[29:15], instr_code[11:7]};

  rv32i_alu_decoder u_alu_decoder (
    .opcode      (opcode),
    .funct3      (instr_code[14:12]),
    .funct7_5    (instr_code[30]),
    .alu_control (alu_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= next_state;
  end

  // Every path ends back in FETCH; illegal opcodes skip via PC+4 straight from DECODE.
  always_comb begin
    next_state    = FETCH;
    pc_en         = 1'b0;
    reg_we        = 1'b0;
    alu_src_sel   = 1'b0;
    alu_control   = ALU_ADD;
    rfwd_sel      = RFWD_ALU;
    pc_sel        = PC_PLUS4;
    dmem_we       = 1'b0;
    illegal_instr = 1'b0;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (opcode)
          OP_R:     next_state = R_EXE;
          OP_I:     next_state = I_EXE;
          OP_B:     next_state = B_EXE;
          OP_LUI:   next_state = LU_EXE;
          OP_AUIPC: next_state = AU_EXE;
          OP_JAL:   next_state = J_EXE;
          OP_JALR:  next_state = JL_EXE;
          OP_S:     next_state = S_EXE;
          OP_L:     next_state = L_EXE;
          default: begin
            next_state    = FETCH;
            illegal_instr = 1'b1;
            pc_en         = 1'b1;
          end
        endcase
      end
      R_EXE: begin
        reg_we      = 1'b1;
        pc_en       = 1'b1;
        alu_control = alu_dec;
      end
      I_EXE: begin
        reg_we      = 1'b1;
        pc_en       = 1'b1;
        alu_src_sel = 1'b1;
        alu_control = alu_dec;
      end
      B_EXE: begin
        pc_en       = 1'b1;
        alu_control = alu_dec;
        pc_sel      = btaken ? PC_BRANCH : PC_PLUS4;
      end
      LU_EXE: begin
        reg_we   = 1'b1;
        pc_en    = 1'b1;
        rfwd_sel = RFWD_IMM;
      end
      AU_EXE: begin
        reg_we   = 1'b1;
        pc_en    = 1'b1;
        rfwd_sel = RFWD_PC_IMM;
      end
      J_EXE: begin
        reg_we   = 1'b1;
        pc_en    = 1'b1;
        rfwd_sel = RFWD_PC_4;
        pc_sel   = PC_BRANCH;
      end
      JL_EXE: begin
        reg_we      = 1'b1;
        pc_en       = 1'b1;
        alu_src_sel = 1'b1;
        rfwd_sel    = RFWD_PC_4;
        pc_sel      = PC_JALR;
      end
      S_EXE: begin
        next_state  = S_MEM;
        alu_src_sel = 1'b1;
      end
      S_MEM: begin
        alu_src_sel = 1'b1;
        dmem_we     = 1'b1;
        pc_en       = 1'b1;
      end
      L_EXE: begin
        next_state  = L_MEM;
        alu_src_sel = 1'b1;
      end
      L_MEM: begin
        next_state  = L_WB;
        alu_src_sel = 1'b1;
      end
      L_WB: begin
        alu_src_sel = 1'b1;
        reg_we      = 1'b1;
        rfwd_sel    = RFWD_DMEM;
        pc_en       = 1'b1;
      end
      default: next_state = FETCH;
    endcase
  end

  assign rfwd_src_sel = rfwd_sel;
  assign pc_src_sel   = pc_sel;

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
// Self-checking bench for rv32i_mc_control_unit: directed instructions plus a random
// instruction stream, each cycle compared against a per-instruction-class timing model.
module tb_rv32i_mc_control_unit;

  typedef struct packed {
    logic       pc_en;
    logic       reg_we;
    logic       alu_src_sel;
    logic [3:0] alu_control;
    logic [2:0] rfwd_src_sel;
    logic [1:0] pc_src_sel;
    logic       dmem_we;
    logic       illegal_instr;
  } outs_t;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_LW   = 32'h00802283;
  localparam logic [31:0] I_SW   = 32'h00202223;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_JAL  = 32'h010000EF;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_SRAI = 32'h40515093;
  localparam logic [31:0] I_ADDI = 32'hFFF00093;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_code = I_ADD;
  logic        btaken = 1'b0;
  logic        pc_en, reg_we, alu_src_sel, dmem_we, illegal_instr;
  logic [3:0]  alu_control;
  logic [2:0]  rfwd_src_sel;
  logic [1:0]  pc_src_sel;
  outs_t       observed;

  int tests_run = 0;
  int tests_failed = 0;

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111, 7'b0010111,
                                7'b1101111, 7'b1100111, 7'b0100011, 7'b0000011};

  rv32i_mc_control_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_code    (instr_code),
    .btaken        (btaken),
    .pc_en         (pc_en),
    .reg_we        (reg_we),
    .alu_src_sel   (alu_src_sel),
    .alu_control   (alu_control),
    .rfwd_src_sel  (rfwd_src_sel),
    .pc_src_sel    (pc_src_sel),
    .dmem_we       (dmem_we),
    .illegal_instr (illegal_instr)
  );

  assign observed = '{pc_en, reg_we, alu_src_sel, alu_control, rfwd_src_sel,
                      pc_src_sel, dmem_we, illegal_instr};

  always #5 clk = ~clk;

  function automatic int latency(input logic [31:0] ins);
    case (ins[6:0])
      7'b0100011: return 4;
      7'b0000011: return 5;
      7'b0110011, 7'b0010011, 7'b1100011, 7'b0110111,
      7'b0010111, 7'b1101111, 7'b1100111: return 3;
      default: return 2;
    endcase
  endfunction

  // Cycle k of an instruction: 0 = fetch, 1 = decode, the final cycle commits.
  function automatic outs_t model(input logic [31:0] ins, input logic bt, input int k);
    outs_t      o = '0;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic       f7 = ins[30];
    int         n = latency(ins);
    if (n == 2) begin
      if (k == 1) begin
        o.pc_en = 1'b1;
        o.illegal_instr = 1'b1;
      end
      return o;
    end
    if (k < 2) return o;
    o.alu_src_sel = (op inside {7'b0010011, 7'b1100111, 7'b0100011, 7'b0000011});
    if (op == 7'b0110011) o.alu_control = {f7, f3};
    if (op == 7'b0010011) o.alu_control = (f3 == 3'b101) ? {f7, f3} : {1'b0, f3};
    if (op == 7'b1100011) o.alu_control = 4'b1000;
    if (k == n - 1) begin
      o.pc_en   = 1'b1;
      o.reg_we  = !(op == 7'b1100011 || op == 7'b0100011);
      o.dmem_we = (op == 7'b0100011);
      if (op == 7'b0000011) o.rfwd_src_sel = 3'd1;
      if (op == 7'b0110111) o.rfwd_src_sel = 3'd2;
      if (op == 7'b0010111) o.rfwd_src_sel = 3'd3;
      if (op == 7'b1101111 || op == 7'b1100111) o.rfwd_src_sel = 3'd4;
      if (op == 7'b1101111) o.pc_src_sel = 2'd1;
      if (op == 7'b1100111) o.pc_src_sel = 2'd2;
      if (op == 7'b1100011) o.pc_src_sel = bt ? 2'd1 : 2'd0;
    end
    return o;
  endfunction

  // Starts just after a rising edge with the DUT in FETCH; returns the same way.
  task automatic run_instr(input string name, input logic [31:0] ins, input logic bt);
    int    n;
    outs_t exp_o;
    n = latency(ins);
    instr_code = ins;
    btaken = bt;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      exp_o = model(ins, bt, k);
      tests_run++;
      if (observed !== exp_o) begin
        tests_failed++;
        $display("[TB] FAIL %s ins=%h cyc %0d: got %h expected %h", name, ins, k, observed, exp_o);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    instr_code = I_ADD;
    btaken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++;
      if (observed !== outs_t'(0)) begin
        tests_failed++;
        $display("[TB] FAIL reset_hold cyc %0d: got %h expected %h", i, observed, outs_t'(0));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr("reset_release_add", I_ADD, 1'b0);
  endtask

  task automatic test_load();
    run_instr("load", I_LW, 1'b0);
  endtask

  task automatic test_store();
    run_instr("store", I_SW, 1'b1);
  endtask

  task automatic test_branch();
    run_instr("branch_taken", I_BEQ, 1'b1);
    run_instr("branch_not_taken", I_BEQ, 1'b0);
  endtask

  task automatic test_jal_illegal();
    run_instr("jal", I_JAL, 1'b0);
    run_instr("illegal", I_ILL, 1'b0);
  endtask

  task automatic test_imm_alu();
    run_instr("srai", I_SRAI, 1'b0);
    run_instr("addi_neg", I_ADDI, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    instr_code = I_LW;
    btaken = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if (observed !== model(I_LW, 1'b0, k)) begin
        tests_failed++;
        $display("[TB] FAIL midload_pre cyc %0d: got %h expected %h", k, observed, model(I_LW, 1'b0, k));
      end
      if (k < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #1;
    reset = 1'b0;
    #1;
    tests_run++;
    if (observed !== outs_t'(0)) begin
      tests_failed++;
      $display("[TB] FAIL midload_async_drop: got %h expected %h", observed, outs_t'(0));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (observed !== outs_t'(0)) begin
        tests_failed++;
        $display("[TB] FAIL midload_no_wb cyc %0d: got %h expected %h", i, observed, outs_t'(0));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_instr("load_after_reset", I_LW, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    logic [6:0]  op;
    int          idx;
    for (int i = 0; i < 80; i++) begin
      r = $urandom();
      idx = $urandom_range(0, 9);
      if (idx < 9) begin
        op = legal_ops[idx];
      end else begin
        op = 7'($urandom_range(0, 127));
        if (latency({25'd0, op}) != 2) op = 7'h7F;
      end
      run_instr("random", {r[31:7], op}, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_jal_illegal();
    test_imm_alu();
    test_reset_mid_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
